// File: rtl/cache_fill_ctrl_pkg.sv
// Shared types and constants for the cache miss fill controller:
// FSM state and fill-owner encodings plus block geometry.
package cache_fill_ctrl_pkg;

    localparam int WORDS_PER_BLOCK_DEF = 8;
    localparam int BYTES_PER_WORD      = 2;
    localparam int BLOCK_OFFSET_BITS   = $clog2(WORDS_PER_BLOCK_DEF * BYTES_PER_WORD);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Main-memory read port shared by both caches; the fill controller is the
// master (issues addresses), the memory model is the slave (returns words).
interface cache_fill_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_enable;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_data_valid;

    modport master (
        output mem_addr,
        output mem_enable,
        input  mem_data_in,
        input  mem_data_valid
    );

    modport slave (
        input  mem_addr,
        input  mem_enable,
        output mem_data_in,
        output mem_data_valid
    );
endinterface

// File: rtl/cache_fill_ctrl_fill_counter.sv
// Resettable up-counter with synchronous clear, increment enable and a
// terminal-count flag; used for both the issue and the return side of a fill.
module fill_counter #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);
    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] r_count;

    // NOTE: state registers use non-blocking assignment and an async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == TC_VAL);

endmodule

// File: rtl/cache_fill_ctrl.sv
// Arbitrates I/D cache misses onto one memory read port and streams each
// returned block word into the missing cache's write port.
module cache_fill_ctrl
    import cache_fill_ctrl_pkg::*;
#(
    parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    cache_fill_ctrl_if.master mem,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              i_fill_we,
    output logic              d_fill_we,
    output logic              i_fill_done,
    output logic              d_fill_done,
    output logic              busy
);
    localparam int OFF_BITS = $clog2(WORDS_PER_BLOCK * BYTES_PER_WORD);
    localparam int CNT_BITS = $clog2(WORDS_PER_BLOCK);

    state_t            r_state, w_next_state;
    owner_t            r_owner;
    logic [ADDR_W-1:0] r_base;
    logic              r_last_d;
    logic              r_i_done, r_d_done;

    logic [CNT_BITS:0]   w_icnt;
    logic [CNT_BITS-1:0] w_rcnt;
    logic                w_issue_tc, w_ret_tc;
    logic                w_fill, w_grant, w_grant_d, w_issue, w_ret, w_last;
    logic [ADDR_W-1:0]   w_miss_addr;

    assign w_fill      = (r_state == S_FILL);
    assign w_grant     = (r_state == S_IDLE) && (i_miss || d_miss);
    // D wins unless both miss and D had the previous grant.
    assign w_grant_d   = d_miss && (!i_miss || !r_last_d);
    assign w_miss_addr = w_grant_d ? d_miss_addr : i_miss_addr;
    assign w_issue     = w_fill && !w_issue_tc;
    assign w_ret       = w_fill && mem.mem_data_valid;
    assign w_last      = w_ret && w_ret_tc;

    fill_counter #(.WIDTH(CNT_BITS + 1), .TERMINAL(WORDS_PER_BLOCK)) u_issue_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_grant),
        .i_inc   (w_issue),
        .o_count (w_icnt),
        .o_tc    (w_issue_tc)
    );

    fill_counter #(.WIDTH(CNT_BITS), .TERMINAL(WORDS_PER_BLOCK - 1)) u_ret_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_grant),
        .i_inc   (w_ret),
        .o_count (w_rcnt),
        .o_tc    (w_ret_tc)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next_state   = r_state;
        mem.mem_enable = 1'b0;
        mem.mem_addr   = '0;
        fill_addr      = '0;
        fill_data      = '0;
        i_fill_we      = 1'b0;
        d_fill_we      = 1'b0;
        case (r_state)
            S_IDLE: if (w_grant) w_next_state = S_FILL;
            S_FILL: if (w_last)  w_next_state = S_IDLE;
            default:             w_next_state = S_IDLE;
        endcase
        if (w_issue) begin
            mem.mem_enable = 1'b1;
            mem.mem_addr   = r_base + (ADDR_W'(w_icnt) << 1);
        end
        if (w_ret) begin
            fill_addr = r_base + (ADDR_W'(w_rcnt) << 1);
            fill_data = mem.mem_data_in;
            i_fill_we = (r_owner == OWN_I);
            d_fill_we = (r_owner == OWN_D);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_owner  <= OWN_I;
            r_base   <= '0;
            r_last_d <= 1'b0;
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_i_done <= w_last && (r_owner == OWN_I);
            r_d_done <= w_last && (r_owner == OWN_D);
            if (w_grant) begin
                r_owner  <= w_grant_d ? OWN_D : OWN_I;
                r_base   <= {w_miss_addr[ADDR_W-1:OFF_BITS], {OFF_BITS{1'b0}}};
                r_last_d <= w_grant_d;
            end
        end
    end

    assign i_fill_done = r_i_done;
    assign d_fill_done = r_d_done;
    assign busy        = w_fill;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: latency memory model, cache miss model,
// and per-word checks of request/write streams and done pulses.
module tb_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, d_miss;
    logic [15:0] i_miss_addr, d_miss_addr;
    logic [15:0] fill_addr, fill_data;
    logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, busy;

    always #5 clk = ~clk;

    cache_fill_ctrl_if #(.ADDR_W(16), .DATA_W(16)) mem_if ();

    cache_fill_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .i_miss      (i_miss),
        .i_miss_addr (i_miss_addr),
        .d_miss      (d_miss),
        .d_miss_addr (d_miss_addr),
        .mem         (mem_if),
        .fill_addr   (fill_addr),
        .fill_data   (fill_data),
        .i_fill_we   (i_fill_we),
        .d_fill_we   (d_fill_we),
        .i_fill_done (i_fill_done),
        .d_fill_done (d_fill_done),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Observation logs
    int          req_cyc[$];
    logic [15:0] req_addr[$];
    int          wr_cyc[$];
    logic [15:0] wr_addr[$];
    logic [15:0] wr_data[$];
    bit          wr_d[$];
    int          done_cyc[$];
    bit          done_d[$];
    int          both_we = 0;

    // Memory model: fixed latency, optional 1-in-3 return gating, stray injection
    logic [15:0] mq_addr[$];
    int          mq_due[$];
    int          lat    = 4;
    bit          gapped = 1'b0;
    bit          stray  = 1'b0;
    int          cyc    = 0;

    task automatic clear_logs();
        req_cyc.delete(); req_addr.delete();
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); wr_d.delete();
        done_cyc.delete(); done_d.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        mem_if.mem_data_valid = 1'b0;
        mem_if.mem_data_in    = 16'h0BAD;
        if (stray) begin
            mem_if.mem_data_valid = 1'b1;
            mem_if.mem_data_in    = 16'hDEAD;
            stray = 1'b0;
        end else if (mq_addr.size() > 0 && mq_due[0] <= cyc && (!gapped || (cyc % 3) == 0)) begin
            mem_if.mem_data_valid = 1'b1;
            mem_if.mem_data_in    = mq_addr[0] ^ 16'h5A5A;
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        @(negedge clk);
        if (mem_if.mem_enable) begin
            req_cyc.push_back(cyc);
            req_addr.push_back(mem_if.mem_addr);
            mq_addr.push_back(mem_if.mem_addr);
            mq_due.push_back(cyc + lat);
        end
        if (i_fill_we || d_fill_we) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(fill_addr);
            wr_data.push_back(fill_data);
            wr_d.push_back(d_fill_we);
        end
        if (i_fill_we && d_fill_we) both_we++;
        if (i_fill_done) begin done_cyc.push_back(cyc); done_d.push_back(1'b0); i_miss = 1'b0; end
        if (d_fill_done) begin done_cyc.push_back(cyc); done_d.push_back(1'b1); d_miss = 1'b0; end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_done(input int n, input string tag);
        int k = 0;
        while (done_cyc.size() < n && k < 200) begin
            tick();
            k++;
        end
        check({tag, "_done_seen"}, done_cyc.size(), n);
    endtask

    // Checks one 8-word fill: requests at t..t+7, writes in order, optionally at t+l+k
    task automatic check_block(input string tag, input int ro, input int wo, input int t,
                               input int l, input logic [15:0] base, input bit own_d,
                               input bit fixed_lat);
        for (int k = 0; k < 8; k++) begin
            logic [15:0] a;
            a = base + 16'(2 * k);
            check($sformatf("%s_req_addr%0d", tag, k),
                  (ro + k < req_addr.size()) ? 32'(req_addr[ro + k]) : 32'hxxxx_xxxx, 32'(a));
            check($sformatf("%s_req_cyc%0d", tag, k),
                  (ro + k < req_cyc.size()) ? 32'(req_cyc[ro + k]) : 32'hxxxx_xxxx, 32'(t + k));
            check($sformatf("%s_wr_addr%0d", tag, k),
                  (wo + k < wr_addr.size()) ? 32'(wr_addr[wo + k]) : 32'hxxxx_xxxx, 32'(a));
            check($sformatf("%s_wr_data%0d", tag, k),
                  (wo + k < wr_data.size()) ? 32'(wr_data[wo + k]) : 32'hxxxx_xxxx, 32'(a ^ 16'h5A5A));
            check($sformatf("%s_wr_owner%0d", tag, k),
                  (wo + k < wr_d.size()) ? 32'(wr_d[wo + k]) : 32'hxxxx_xxxx, 32'(own_d));
            if (fixed_lat)
                check($sformatf("%s_wr_cyc%0d", tag, k),
                      (wo + k < wr_cyc.size()) ? 32'(wr_cyc[wo + k]) : 32'hxxxx_xxxx, 32'(t + l + k));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_enable"}, mem_if.mem_enable, 0);
        check({tag, "_mem_addr"},   mem_if.mem_addr,   0);
        check({tag, "_fill_addr"},  fill_addr,         0);
        check({tag, "_fill_data"},  fill_data,         0);
        check({tag, "_we"},         {i_fill_we, d_fill_we}, 0);
        check({tag, "_done"},       {i_fill_done, d_fill_done}, 0);
        check({tag, "_busy"},       busy,              0);
    endtask

    initial begin
        int t, t2, t3;
        rst = 1'b0;
        i_miss = 1'b0; d_miss = 1'b0;
        i_miss_addr = 16'h0; d_miss_addr = 16'h0;
        mem_if.mem_data_valid = 1'b0;
        mem_if.mem_data_in    = 16'h0;

        // Reset state
        ticks(2);
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // D-only miss, L=4
        clear_logs();
        lat = 4;
        d_miss_addr = 16'h1236;
        d_miss = 1'b1;
        t = cyc + 1;
        tick();
        check("donly_busy", busy, 1);
        wait_done(1, "donly");
        ticks(3);
        check_block("donly", 0, 0, t, 4, 16'h1230, 1'b1, 1'b1);
        check("donly_done_cyc", done_cyc[0], t + 12);
        check("donly_done_is_d", done_d[0], 1);
        check("donly_req_count", req_addr.size(), 8);
        check("donly_wr_count", wr_addr.size(), 8);
        check("donly_done_count", done_cyc.size(), 1);

        // Collision from reset: D, then I, then D again; L=3
        rst = 1'b0;
        i_miss_addr = 16'h2468;
        d_miss_addr = 16'h8ACE;
        i_miss = 1'b1;
        d_miss = 1'b1;
        tick();
        rst = 1'b1;
        clear_logs();
        lat = 3;
        t = cyc + 1;
        wait_done(1, "col1");
        wait_done(2, "col2");
        t2 = t + 3 + 9;
        check_block("col_d", 0, 0, t, 3, 16'h8AC0, 1'b1, 1'b1);
        check_block("col_i", 8, 8, t2, 3, 16'h2460, 1'b0, 1'b1);
        check("col_done0_cyc", done_cyc[0], t + 11);
        check("col_done0_is_d", done_d[0], 1);
        check("col_done1_cyc", done_cyc[1], t2 + 11);
        check("col_done1_is_d", done_d[1], 0);
        i_miss_addr = 16'h3000;
        d_miss_addr = 16'h0012;
        i_miss = 1'b1;
        d_miss = 1'b1;
        t3 = cyc + 1;
        wait_done(3, "col3");
        i_miss = 1'b0;
        ticks(3);
        check("col3_done_is_d", done_d[2], 1);
        check("col3_req_addr0", req_addr[16], 16'h0010);
        check("col3_req_cyc0", req_cyc[16], t3);
        check("col_req_count", req_addr.size(), 24);

        // Gapped returns, 1 in 3 cycles, L=2
        clear_logs();
        lat = 2;
        gapped = 1'b1;
        d_miss_addr = 16'h4442;
        d_miss = 1'b1;
        t = cyc + 1;
        wait_done(1, "gap");
        gapped = 1'b0;
        ticks(3);
        check_block("gap", 0, 0, t, 2, 16'h4440, 1'b1, 1'b0);
        check("gap_req_count", req_addr.size(), 8);
        check("gap_wr_count", wr_addr.size(), 8);
        check("gap_done_count", done_cyc.size(), 1);
        check("gap_wr_span", wr_cyc[7] - wr_cyc[0], 21);
        check("gap_done_after_last", done_cyc[0], wr_cyc[7] + 1);

        // Reset after word 3 written
        clear_logs();
        lat = 4;
        i_miss_addr = 16'h0A0C;
        i_miss = 1'b1;
        t = cyc + 1;
        for (int k = 0; k < 50 && wr_addr.size() < 4; k++) tick();
        check("rstmid_wr3_cyc", wr_cyc.size() == 4 ? wr_cyc[3] : -1, t + 7);
        rst = 1'b0;
        i_miss = 1'b0;
        #1;
        check("rstmid_valid_still_high", mem_if.mem_data_valid, 1);
        check_all_zero("rstmid");
        ticks(2);
        rst = 1'b1;
        ticks(6);
        check("rstmid_wr_count", wr_addr.size(), 4);
        check("rstmid_done_count", done_cyc.size(), 0);
        check("rstmid_req_count", req_addr.size(), 8);
        check("rstmid_queue_drained", mq_addr.size(), 0);

        // Address wrap at top of memory, then a stray return in IDLE
        clear_logs();
        lat = 4;
        i_miss_addr = 16'hFFF8;
        i_miss = 1'b1;
        t = cyc + 1;
        wait_done(1, "wrap");
        ticks(2);
        check_block("wrap", 0, 0, t, 4, 16'hFFF0, 1'b0, 1'b1);
        check("wrap_done_is_i", done_d[0], 0);
        stray = 1'b1;
        tick();
        check("stray_we", {i_fill_we, d_fill_we}, 0);
        check("stray_fill_data", fill_data, 0);
        ticks(2);
        check("stray_wr_count", wr_addr.size(), 8);
        check("stray_done_count", done_cyc.size(), 1);

        check("never_both_we", both_we, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Miss-handling controller that shares the single main-memory read port between the instruction cache and the data cache. On a miss it fetches the whole 8-word block from memory and streams each returned word into the missing cache through that cache's write port. Sits between both cache instances and the memory model, beside the pipeline's stall logic.

## Interface
- `WORDS_PER_BLOCK`, default 8: words per cache block; a power of two.
- `ADDR_W`, default 16: byte address width.
- `DATA_W`, default 16: word width; 2 bytes per word.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_miss`  in  1  I-cache miss, combinational from the I-cache.
- `i_miss_addr`  in  16  I-cache miss byte address.
- `d_miss`  in  1  D-cache miss.
- `d_miss_addr`  in  16  D-cache miss byte address.
- `mem_data_in`  in  16  memory read data.
- `mem_data_valid`  in  1  `mem_data_in` is valid this cycle.
- `mem_addr`  out  16  memory read address.
- `mem_enable`  out  1  memory read request this cycle.
- `fill_addr`  out  16  cache write address; drives the owner cache's `Address` during a fill.
- `fill_data`  out  16  cache write data.
- `i_fill_we`  out  1  I-cache `Write_Enable`.
- `d_fill_we`  out  1  D-cache `Write_Enable`.
- `i_fill_done`  out  1  one-cycle pulse after the I-block is complete.
- `d_fill_done`  out  1  one-cycle pulse after the D-block is complete.
- `busy`  out  1  high in FILL.

## Operation
- States: IDLE and FILL.
- Registers:
  - `owner` (I or D)
  - `base`, the block address with `addr[3:0]` cleared
  - `icnt`, the issue counter (0..8)
  - `rcnt`, the return counter (0..7)
  - `last_d`, which records the last grant
- IDLE, arbitration:
  - Only `d_miss`: grant D.
  - Only `i_miss`: grant I.
  - Both: grant I if `last_d`=1, else D. Round-robin on collision; otherwise D has priority.
- On grant:
  - Latch `owner` and `base`.
  - Clear `icnt` and `rcnt`.
  - Update `last_d`.
  - Go to FILL.
- FILL, issue side:
  - While `icnt` < 8: `mem_enable`=1, `mem_addr` = `base` + 2·`icnt`, `icnt`++.
  - Once `icnt` = 8: `mem_enable`=0.
- FILL, return side:
  - On `mem_data_valid`: owner `*_fill_we`=1, `fill_addr` = `base` + 2·`rcnt`, `fill_data` = `mem_data_in`, `rcnt`++.
  - The controller counts valid pulses and does not assume a fixed memory latency.
  - The cache writes tag and valid on every word, so the block is valid once word 7 is written.
- Completion:
  - `mem_data_valid` with `rcnt`=7 writes the last word.
  - Next edge: state goes to IDLE and the owner's `*_fill_done` pulses high for exactly one cycle.
- IDLE always lasts at least one cycle. This gives the refilled cache a cycle to report a hit and drop its miss before arbitration is re-evaluated.
- Outside FILL:
  - `*_fill_we`=0, `mem_enable`=0.
  - `mem_data_valid` is ignored (stray returns are dropped).
- Miss inputs are sampled only in IDLE. Changes to them during FILL are ignored.
- Never: both `*_fill_we` high in the same cycle; more than 8 requests per fill.

## Timing
- Reset values:
  - State IDLE; all counters 0; `owner`=I; `last_d`=0; `base`=0.
  - All outputs 0, including `mem_addr`, `fill_addr` and `fill_data`.
- Reset asserted mid-fill: abort immediately with no done pulse. Returns still in flight after reset are ignored.
- Grant at edge T. Requests are issued in cycles T..T+7, words 0..7 in order.
- Memory with latency L: writes occur in cycles T+L..T+L+7. The done pulse is in cycle T+L+8. The earliest next grant is edge T+L+9.
- `fill_*` and `*_fill_we` are combinational from `mem_data_valid` and registered state.
- `mem_addr` and `mem_enable` are combinational from registered state.
- Done pulses are registered.
- Address arithmetic is modulo 2^16. A block at 0xFFF0 fetches 0xFFF0..0xFFFE without carry out.

## Structure
- Shared package: state encoding (IDLE, FILL), the owner encoding, and `BLOCK_OFFSET_BITS` = log2(`WORDS_PER_BLOCK`·2) = 4.
- One sub-module: `fill_counter`, a resettable up-counter with increment enable and terminal-count flag. It is instantiated twice, for issue and return.

## Test plan
- **D-only miss:** `d_miss`=1, `d_miss_addr`=0x1236, memory L=4.
  - Requests at 0x1230..0x123E on 8 consecutive cycles.
  - `d_fill_we` for 8 cycles starting 4 cycles later, `fill_addr` 0x1230..0x123E.
  - `d_fill_done` 1 cycle after the last write.
  - `i_fill_we` never asserts.
- **Collision:** `i_miss` and `d_miss` both high from reset.
  - D is granted first, then I (via `last_d`).
  - A second D+I collision afterwards grants D.
- **Irregular returns:** `mem_data_valid` gapped, 1 of every 3 cycles.
  - Exactly 8 writes, in order, with no extra requests.
  - Done only after the 8th valid.
- **Reset mid-fill:** `rst` low after word 3 is written.
  - All outputs 0 at once.
  - Later valids produce no writes and no done pulse.
- **Wrap:** `i_miss_addr`=0xFFF8.
  - Requests at 0xFFF0..0xFFFE.
  - A stray `mem_data_valid` in IDLE produces no write.
